// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle RISC controller: FSM states,
// instruction field codes and datapath mux select encodings.
package cpu_pkg;

   typedef enum logic [4:0] {
      S_RESET,
      S_FETCH,
      S_LOAD_IR,
      S_DECODE,
      S_WR_IMM,
      S_GET_A,
      S_GET_B,
      S_CALC,
      S_CALC_MOV,
      S_WR_REG,
      S_CMP,
      S_ADDR,
      S_LD_ADDR,
      S_MEM_RD,
      S_WR_MEM,
      S_GET_BD,
      S_STR_CALC,
      S_MEM_WR,
      S_BRANCH,
      S_HALT
   } state_t;

   localparam logic [2:0] OP_B    = 3'b001;
   localparam logic [2:0] OP_LDR  = 3'b011;
   localparam logic [2:0] OP_STR  = 3'b100;
   localparam logic [2:0] OP_ALU  = 3'b101;
   localparam logic [2:0] OP_MOV  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_CMP = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;
   localparam logic [1:0] MOV_REG = 2'b00;
   localparam logic [1:0] MOV_IMM = 2'b10;

   localparam logic [2:0] COND_AL = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_NE = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_LE = 3'b100;

   localparam logic [1:0] REG_RM = 2'b00;
   localparam logic [1:0] REG_RD = 2'b01;
   localparam logic [1:0] REG_RN = 2'b10;

   localparam logic [1:0] WB_C     = 2'b00;
   localparam logic [1:0] WB_PC    = 2'b01;
   localparam logic [1:0] WB_IMM   = 2'b10;
   localparam logic [1:0] WB_MDATA = 2'b11;

endpackage

// File: rtl/cpu_controller_branch_cond.sv
// Combinational branch condition evaluation from the IR cond field and the
// Z/N/V status flags.
module branch_cond
   import cpu_pkg::*;
(
   input  logic [2:0] cond,
   input  logic       z,
   input  logic       n,
   input  logic       v,
   output logic       take
);

   always_comb begin
      take = 1'b0;
      case (cond)
         COND_AL: take = 1'b1;
         COND_EQ: take = z;
         COND_NE: take = ~z;
         COND_LT: take = n ^ v;
         COND_LE: take = z | (n ^ v);
         default: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// Moore FSM sequencing the multi-cycle datapath: fetch, decode, execute.
// Build option: BRANCH_COND_EN enables conditional branches (BEQ/BNE/BLT/BLE).
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int RAM_RD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic [1:0] ALU_op,
   input  logic [2:0] cond,
   input  logic       Z_out,
   input  logic       N_out,
   input  logic       V_out,
   output logic       waiting,
   output logic [1:0] reg_sel,
   output logic [1:0] wb_sel,
   output logic       w_en,
   output logic       en_A,
   output logic       en_B,
   output logic       sel_A,
   output logic       sel_B,
   output logic       en_C,
   output logic       en_status,
   output logic       load_ir,
   output logic       load_pc,
   output logic       clear_pc,
   output logic       pc_sel,
   output logic       sel_addr,
   output logic       load_addr,
   output logic       ram_w_en
);

   localparam logic [1:0] LAT_LAST = 2'(RAM_RD_LAT - 1);

   state_t     state_reg, state_next;
   logic [1:0] cnt_reg, cnt_next;
   logic       take_br;

`ifdef BRANCH_COND_EN
   branch_cond u_branch_cond (
      .cond (cond),
      .z    (Z_out),
      .n    (N_out),
      .v    (V_out),
      .take (take_br)
   );
`else
   logic unused_flags;
   assign unused_flags = Z_out ^ N_out ^ V_out;
   assign take_br      = (cond == COND_AL);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_RESET;
         cnt_reg   <= 2'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Wait counter only runs while a RAM-latency state is being held.
   always_comb begin
      cnt_next = 2'd0;
      if ((state_next == state_reg) &&
          ((state_reg == S_FETCH) || (state_reg == S_MEM_RD)))
         cnt_next = cnt_reg + 2'd1;
   end

   always_comb begin
      state_next = S_FETCH;
      waiting    = 1'b0;
      reg_sel    = REG_RM;
      wb_sel     = WB_C;
      w_en       = 1'b0;
      en_A       = 1'b0;
      en_B       = 1'b0;
      sel_A      = 1'b0;
      sel_B      = 1'b0;
      en_C       = 1'b0;
      en_status  = 1'b0;
      load_ir    = 1'b0;
      load_pc    = 1'b0;
      clear_pc   = 1'b0;
      pc_sel     = 1'b0;
      sel_addr   = 1'b0;
      load_addr  = 1'b0;
      ram_w_en   = 1'b0;
      case (state_reg)
         S_RESET: begin
            waiting  = 1'b1;
            clear_pc = 1'b1;
            load_pc  = 1'b1;
            sel_addr = 1'b1;
         end
         S_FETCH: begin
            sel_addr   = 1'b1;
            state_next = (cnt_reg == LAT_LAST) ? S_LOAD_IR : S_FETCH;
         end
         S_LOAD_IR: begin
            load_ir    = 1'b1;
            load_pc    = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_MOV: begin
                  if (ALU_op == MOV_IMM)      state_next = S_WR_IMM;
                  else if (ALU_op == MOV_REG) state_next = S_GET_B;
               end
               OP_ALU:  state_next = (ALU_op == ALU_MVN) ? S_GET_B : S_GET_A;
               OP_LDR,
               OP_STR:  state_next = S_GET_A;
               OP_B:    state_next = take_br ? S_BRANCH : S_FETCH;
               OP_HALT: state_next = S_HALT;
               default: state_next = S_FETCH;
            endcase
         end
         S_WR_IMM: begin
            reg_sel = REG_RN;
            wb_sel  = WB_IMM;
            w_en    = 1'b1;
         end
         S_GET_A: begin
            reg_sel    = REG_RN;
            en_A       = 1'b1;
            state_next = ((opcode == OP_LDR) || (opcode == OP_STR)) ? S_ADDR : S_GET_B;
         end
         S_GET_B: begin
            reg_sel = REG_RM;
            en_B    = 1'b1;
            // IR is stable through execute, so the instruction still selects the path.
            if (opcode == OP_ALU && ALU_op == ALU_CMP)
               state_next = S_CMP;
            else if (opcode == OP_ALU && (ALU_op == ALU_ADD || ALU_op == ALU_AND))
               state_next = S_CALC;
            else
               state_next = S_CALC_MOV;
         end
         S_CALC: begin
            en_C       = 1'b1;
            state_next = S_WR_REG;
         end
         S_CALC_MOV: begin
            sel_A      = 1'b1;
            en_C       = 1'b1;
            state_next = S_WR_REG;
         end
         S_WR_REG: begin
            reg_sel = REG_RD;
            wb_sel  = WB_C;
            w_en    = 1'b1;
         end
         S_CMP: en_status = 1'b1;
         S_ADDR: begin
            sel_B      = 1'b1;
            en_C       = 1'b1;
            state_next = S_LD_ADDR;
         end
         S_LD_ADDR: begin
            load_addr  = 1'b1;
            state_next = (opcode == OP_LDR) ? S_MEM_RD : S_GET_BD;
         end
         S_MEM_RD: state_next = (cnt_reg == LAT_LAST) ? S_WR_MEM : S_MEM_RD;
         S_WR_MEM: begin
            reg_sel = REG_RD;
            wb_sel  = WB_MDATA;
            w_en    = 1'b1;
         end
         S_GET_BD: begin
            reg_sel    = REG_RD;
            en_B       = 1'b1;
            state_next = S_STR_CALC;
         end
         S_STR_CALC: begin
            sel_A      = 1'b1;
            en_C       = 1'b1;
            state_next = S_MEM_WR;
         end
         S_MEM_WR: ram_w_en = 1'b1;
         S_BRANCH: begin
            load_pc = 1'b1;
            pc_sel  = 1'b1;
         end
         S_HALT: begin
            waiting    = 1'b1;
            state_next = S_HALT;
         end
         default: state_next = S_RESET;
      endcase
   end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Moore FSM that sequences the multi-cycle RISC datapath. Each instruction is fetched from RAM, latched into the IR, and decoded. The FSM then drives the datapath enables, selects and RAM write strobe for that instruction. It sits in the CPU top between the instruction decoder outputs (opcode, ALU_op, cond), the datapath status flags and the RAM/PC/address registers.

Parameters:
RAM_RD_LAT, 1, number of wait cycles after an address is presented before RAM data is valid (legal values 1 to 3).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  3  IR[15:13] from the decoder
ALU_op  in  2  IR[12:11] from the decoder
cond  in  3  IR[10:8] branch condition
Z_out  in  1  zero flag from the status register
N_out  in  1  negative flag from the status register
V_out  in  1  overflow flag from the status register
waiting  out  1  high in RESET and HALT
reg_sel  out  2  register port select: 00=Rm, 01=Rd, 10=Rn
wb_sel  out  2  writeback source: 00=C, 01=PC, 10=sximm8, 11=mdata
w_en  out  1  register file write
en_A  out  1  load A register
en_B  out  1  load B register
sel_A  out  1  1 selects zero for ALU input A
sel_B  out  1  1 selects sximm5 for ALU input B
en_C  out  1  load C register
en_status  out  1  load status register
load_ir  out  1  load IR from RAM
load_pc  out  1  update PC
clear_pc  out  1  PC takes start_pc when load_pc is also high
pc_sel  out  1  branch target select: 0=PC+1, 1=PC+1+sximm8
sel_addr  out  1  RAM address source: 1=PC, 0=data address register
load_addr  out  1  load data address register from C
ram_w_en  out  1  RAM write strobe

Behaviour:
- All outputs are decoded from the state register only. Outputs not listed for a state are 0.
- rst_n low forces RESET asynchronously from any state, including mid-instruction. RESET outputs: waiting=1, clear_pc=1, load_pc=1, sel_addr=1, all others 0.
- Fetch sequence, state: outputs, next state:
  - RESET → FETCH.
  - FETCH: sel_addr=1. Held for RAM_RD_LAT cycles (internal counter) → LOAD_IR.
  - LOAD_IR: load_ir=1, load_pc=1, pc_sel=0 → DECODE.
  - DECODE: no outputs; dispatches on opcode and ALU_op.
- Execute sequences, cycle count after DECODE:
  - MOV imm (110/10), 1 cycle: WR_IMM (reg_sel=10, wb_sel=10, w_en).
  - MOV reg (110/00), 3 cycles: GET_B (reg_sel=00, en_B), CALC (sel_A=1, en_C), WR_REG (reg_sel=01, wb_sel=00, w_en).
  - MVN (101/11), 3 cycles: same path as MOV reg.
  - ADD (101/00) and AND (101/10), 4 cycles: GET_A (reg_sel=10, en_A), GET_B, CALC (sel_A=0), WR_REG.
  - CMP (101/01), 3 cycles: GET_A, GET_B, CMP (en_status, en_C=0).
  - LDR (011), 4+RAM_RD_LAT cycles: GET_A, ADDR (sel_B=1, en_C), LD_ADDR (load_addr), MEM_RD (sel_addr=0, held RAM_RD_LAT cycles), WR_MEM (reg_sel=01, wb_sel=11, w_en).
  - STR (100), 6 cycles: GET_A, ADDR, LD_ADDR, GET_BD (reg_sel=01, en_B), STR_CALC (sel_A=1, en_C), MEM_WR (sel_addr=0, ram_w_en for exactly one cycle).
  - B (001, cond=000), 1 cycle: BRANCH (load_pc, pc_sel=1).
  - HALT (111): HALT state, waiting=1, no other outputs; left only by reset.
- After the last execute state, the next state is FETCH.
- Any other opcode/ALU_op combination → FETCH as a NOP, with no write.
- Flags are sampled only in DECODE; a status update in a CMP is visible to the following instruction.

Optional Feature:
BRANCH_COND_EN.
- Defined: DECODE also dispatches opcode 001 with cond 001=BEQ (Z), 010=BNE (!Z), 011=BLT (N^V), 100=BLE (Z|(N^V)). Condition true → BRANCH; false → FETCH. Codes 101–111 are NOPs.
- Undefined: only cond=000 branches; every other cond is a NOP → FETCH.

Decomposition:
- Package cpu_pkg holds:
  - state_t enum;
  - opcode constants OP_MOV, OP_ALU, OP_LDR, OP_STR, OP_B, OP_HALT;
  - ALU_op constants;
  - cond codes;
  - reg_sel and wb_sel encodings.
- One sub-module, branch_cond: combinational evaluation of cond, Z, N, V to a take signal; instantiated only under BRANCH_COND_EN.

Test Plan:
- rst_n low 2 cycles, release, opcode=110/ALU_op=10 → states RESET, FETCH, LOAD_IR, DECODE, WR_IMM; at WR_IMM w_en=1, wb_sel=10, reg_sel=10; back to FETCH next cycle.
- ADD (101/00) → en_A at DECODE+1, en_B at +2, en_C at +3, w_en with wb_sel=00 at +4; never en_status.
- CMP (101/01) → en_status=1 for exactly one cycle at DECODE+3; w_en stays 0 throughout.
- STR with RAM_RD_LAT=1 → load_addr at DECODE+3, ram_w_en=1 with sel_addr=0 only at DECODE+6; LDR → w_en with wb_sel=11 at DECODE+5.
- HALT → waiting=1 and load_pc=0 for 20 cycles; rst_n low mid-HALT → RESET outputs immediately, before the next clock edge.
- B with cond=000 → load_pc=1, pc_sel=1 at DECODE+1. With BRANCH_COND_EN, BEQ with Z=1 → BRANCH and with Z=0 → FETCH. Without the macro, BEQ → FETCH regardless of Z.
